button_debouncer: RTL and testbench
===================================

Name: button_debouncer

Overview:
- Front-end stage for a mechanical push button. It sits directly upstream of the push-button instruction-controlled status block and drives that block's press input.
- Synchronises the raw asynchronous pad signal into the clock domain and rejects bounce and glitches shorter than Wait cycles.
- Emits one-cycle press and release pulses plus a debounced level.
- The downstream block latches button_pressed into its sticky status, so every press must produce exactly one pulse.

Parameters:
Wait, 40000, number of consecutive stable synchronised samples required to accept a level change; legal range 1..2^Size.
Size, 16, width of the stability counter; must satisfy Wait-1 < 2^Size.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
button  input  1  raw button pad, asynchronous, 1 = pushed
button_pressed  output  1  one-cycle pulse on an accepted press
button_released  output  1  one-cycle pulse on an accepted release
button_level  output  1  debounced button level, 1 = held

Behaviour:
- Interface: reset is reset, synchronous, active-high; clock is clock. All state changes occur on the posedge of clock; all outputs are registered.
- Synchroniser: two flops, button -> s_Sync0 -> s_Sync1. Only s_Sync1 feeds the FSM. Both flops reset to 0.
- Counter s_Count is Size bits wide, resets to 0, and never wraps. It is compared against Wait-1 and cleared on every state entry.
- FSM states: Released, PressWait, Pressed, ReleaseWait. Reset state is Released.
- Released: if s_Sync1=1, go to PressWait with count=0; otherwise stay.
- PressWait, s_Sync1=0: go to Released and clear count. This is glitch rejection; no pulse is produced.
- PressWait, s_Sync1=1 and count==Wait-1: go to Pressed and set button_pressed=1 for exactly one cycle.
- PressWait, s_Sync1=1 and count below Wait-1: increment count.
- Pressed: if s_Sync1=0, go to ReleaseWait with count=0; otherwise stay. Holding the button never re-pulses.
- ReleaseWait, s_Sync1=1: return to Pressed and clear count; no pulse.
- ReleaseWait, s_Sync1=0 and count==Wait-1: go to Released and set button_released=1 for one cycle.
- ReleaseWait, s_Sync1=0 and count below Wait-1: increment count.
- button_level is 1 exactly while the state is Pressed or ReleaseWait. It changes on the same edge as the corresponding pulse.
- Illegal state encodings recover to Released on the next edge with count=0; no pulse is emitted.
- Reset values: button_pressed=0, button_released=0, button_level=0, state=Released, count=0.
- Latency: let edge E0 be the first edge that samples button=1, with button stable thereafter.
  - s_Sync1=1 after E0+1; PressWait is entered at E0+2.
  - button_pressed is high in the cycle following edge E0+Wait+2 and low again after E0+Wait+3.
  - Release is symmetric: button_released and the button_level fall both occur at edge R0+Wait+2.
- Wait=1: a level change is accepted on the edge after entering the wait state, giving a latency of 3 edges.
- Reset mid-operation: asserting reset in any state clears everything on that edge; pulses in flight are dropped.
  - If the button is still held when reset deasserts, it is treated as a fresh press and pulses after full latency.
- Pulses are mutually exclusive; button_pressed and button_released are never high in the same cycle.

Test Plan (Wait=4, Size=4 unless noted):
- Clean press: button 0->1 sampled at edge 0 and held -> button_pressed=1 only during the cycle after edge 6; button_level=1 from edge 6 on; no further pulses while held 100 cycles.
- Bounce on press: button toggles 1,0,1,1,0 on successive edges, then stable 1 from edge 10 -> exactly one button_pressed pulse, after edge 16; no pulse before.
- Short glitch: 3-cycle high pulse on button -> no button_pressed, button_level stays 0, state returns to Released, count=0.
- Release: from Pressed, button 1->0 at edge 0 -> button_released=1 only after edge 6; button_level falls at edge 6; a 2-cycle low glitch while held yields no release.
- Reset mid-wait: assert reset at edge 4 of a press (in PressWait), deassert at edge 5 with button held -> all outputs 0 at edge 4; button_pressed after edge 5+6=11.
- Defaults: Wait=40000, Size=16, press held -> button_pressed after edge 40002 exactly; count never exceeds 39999.

Source files
------------

// File: rtl/button_debouncer_if.sv
// Button pad and debounced pulse/level bundle between the pad driver and the debouncer.
interface button_debouncer_if;
  logic button;
  logic button_pressed;
  logic button_released;
  logic button_level;

  modport master (
    output button,
    input  button_pressed,
    input  button_released,
    input  button_level
  );

  modport slave (
    input  button,
    output button_pressed,
    output button_released,
    output button_level
  );
endinterface

// File: rtl/button_debouncer.sv
// Push-button front end: two-flop synchroniser followed by a stability-counting FSM
// that emits exactly one press/release pulse per accepted level change.
module button_debouncer #(
  parameter int Wait = 40000,
  parameter int Size = 16
) (
  input  logic         clock,
  input  logic         reset,
  button_debouncer_if.slave bus
);

  typedef enum logic [1:0] {
    Released    = 2'd0,
    PressWait   = 2'd1,
    Pressed     = 2'd2,
    ReleaseWait = 2'd3
  } state_t;

  localparam logic [Size-1:0] LastCount = Size'(Wait - 1);

  state_t          state;
  logic            s_Sync0;
  logic            s_Sync1;
  logic [Size-1:0] s_Count;

  // The pad is asynchronous; only the second flop is safe to feed the FSM.
  always_ff @(posedge clock) begin
    if (reset) begin
      s_Sync0 <= 1'b0;
      s_Sync1 <= 1'b0;
    end else begin
      s_Sync0 <= bus.button;
      s_Sync1 <= s_Sync0;
    end
  end

  // Counter is cleared on every state entry and only advances below LastCount,
  // so it can never wrap; pulses default low and last a single cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state               <= Released;
      s_Count             <= '0;
      bus.button_pressed  <= 1'b0;
      bus.button_released <= 1'b0;
      bus.button_level    <= 1'b0;
    end else begin
      bus.button_pressed  <= 1'b0;
      bus.button_released <= 1'b0;
      case (state)
        Released: begin
          if (s_Sync1) begin
            state   <= PressWait;
            s_Count <= '0;
          end
        end
        PressWait: begin
          if (!s_Sync1) begin
            state   <= Released;
            s_Count <= '0;
          end else if (s_Count == LastCount) begin
            state              <= Pressed;
            s_Count            <= '0;
            bus.button_pressed <= 1'b1;
            bus.button_level   <= 1'b1;
          end else begin
            s_Count <= s_Count + 1'b1;
          end
        end
        Pressed: begin
          if (!s_Sync1) begin
            state   <= ReleaseWait;
            s_Count <= '0;
          end
        end
        ReleaseWait: begin
          if (s_Sync1) begin
            state   <= Pressed;
            s_Count <= '0;
          end else if (s_Count == LastCount) begin
            state               <= Released;
            s_Count             <= '0;
            bus.button_released <= 1'b1;
            bus.button_level    <= 1'b0;
          end else begin
            s_Count <= s_Count + 1'b1;
          end
        end
        default: begin
          state            <= Released;
          s_Count          <= '0;
          bus.button_level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: small instance (Wait=4, Size=4) for the scenarios,
// plus a default-parameter instance for the full-latency check.
module tb_button_debouncer;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  button_debouncer_if bus ();
  button_debouncer_if bus2 ();

  button_debouncer #(.Wait(4), .Size(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  button_debouncer dut2 (
    .clock (clock),
    .reset (reset),
    .bus   (bus2.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    bus.button  = 1'b0;
    bus2.button = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.button_pressed !== 1'b0 || bus.button_released !== 1'b0 || bus.button_level !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got p=%b r=%b l=%b, want 0 0 0",
               bus.button_pressed, bus.button_released, bus.button_level);
    end
    checks++;
    if (dut.s_Count !== 4'd0 || dut.state !== 2'd0) begin
      failures++;
      $display("[TB] FAIL reset_state: got count=%0d state=%0d, want 0 0", dut.s_Count, dut.state);
    end
    checks++;
    if (bus2.button_pressed !== 1'b0 || bus2.button_level !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_default_inst: got p=%b l=%b, want 0 0",
               bus2.button_pressed, bus2.button_level);
    end
    reset = 1'b0;
  endtask

  task automatic test_clean_press();
    bus.button = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      tick();
      checks++;
      if (bus.button_pressed !== (e == 6) || bus.button_level !== (e >= 6) || bus.button_released !== 1'b0) begin
        failures++;
        $display("[TB] FAIL clean_press edge %0d: got p=%b l=%b r=%b, want p=%b l=%b r=0",
                 e, bus.button_pressed, bus.button_level, bus.button_released, e == 6, e >= 6);
      end
    end
    for (int e = 0; e < 100; e++) begin
      tick();
      checks++;
      if (bus.button_pressed !== 1'b0 || bus.button_level !== 1'b1 || bus.button_released !== 1'b0) begin
        failures++;
        $display("[TB] FAIL hold_no_repulse cycle %0d: got p=%b l=%b r=%b, want 0 1 0",
                 e, bus.button_pressed, bus.button_level, bus.button_released);
      end
    end
  endtask

  // Starts in Pressed with the button held.
  task automatic test_release();
    for (int e = 0; e <= 9; e++) begin
      bus.button = (e >= 2);
      tick();
      checks++;
      if (bus.button_released !== 1'b0 || bus.button_level !== 1'b1 || bus.button_pressed !== 1'b0) begin
        failures++;
        $display("[TB] FAIL release_glitch edge %0d: got r=%b l=%b p=%b, want 0 1 0",
                 e, bus.button_released, bus.button_level, bus.button_pressed);
      end
    end
    bus.button = 1'b0;
    for (int e = 0; e <= 8; e++) begin
      tick();
      checks++;
      if (bus.button_released !== (e == 6) || bus.button_level !== (e < 6) || bus.button_pressed !== 1'b0) begin
        failures++;
        $display("[TB] FAIL release edge %0d: got r=%b l=%b p=%b, want r=%b l=%b p=0",
                 e, bus.button_released, bus.button_level, bus.button_pressed, e == 6, e < 6);
      end
    end
  endtask

  task automatic test_bounce();
    logic [9:0] pattern;
    pulse_reset();
    pattern = 10'b0110100000;
    for (int e = 0; e <= 18; e++) begin
      bus.button = (e >= 10) ? 1'b1 : pattern[e];
      tick();
      checks++;
      if (bus.button_pressed !== (e == 16) || bus.button_level !== (e >= 16)) begin
        failures++;
        $display("[TB] FAIL bounce edge %0d: got p=%b l=%b, want p=%b l=%b",
                 e, bus.button_pressed, bus.button_level, e == 16, e >= 16);
      end
    end
  endtask

  task automatic test_glitch();
    pulse_reset();
    for (int e = 0; e <= 11; e++) begin
      bus.button = (e < 3);
      tick();
      checks++;
      if (bus.button_pressed !== 1'b0 || bus.button_level !== 1'b0) begin
        failures++;
        $display("[TB] FAIL glitch edge %0d: got p=%b l=%b, want 0 0",
                 e, bus.button_pressed, bus.button_level);
      end
    end
    checks++;
    if (dut.state !== 2'd0 || dut.s_Count !== 4'd0) begin
      failures++;
      $display("[TB] FAIL glitch_recover: got state=%0d count=%0d, want 0 0", dut.state, dut.s_Count);
    end
    bus.button = 1'b1;
    for (int e = 0; e <= 7; e++) begin
      tick();
      checks++;
      if (bus.button_pressed !== (e == 6)) begin
        failures++;
        $display("[TB] FAIL press_after_glitch edge %0d: got p=%b, want %b", e, bus.button_pressed, e == 6);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    pulse_reset();
    bus.button = 1'b1;
    for (int e = 0; e <= 12; e++) begin
      reset = (e == 4);
      tick();
      if (e == 4) begin
        checks++;
        if (bus.button_pressed !== 1'b0 || bus.button_level !== 1'b0 || bus.button_released !== 1'b0 ||
            dut.s_Count !== 4'd0 || dut.state !== 2'd0) begin
          failures++;
          $display("[TB] FAIL mid_wait_reset: got p=%b l=%b r=%b count=%0d state=%0d, want all 0",
                   bus.button_pressed, bus.button_level, bus.button_released, dut.s_Count, dut.state);
        end
      end
      checks++;
      if (bus.button_pressed !== (e == 11)) begin
        failures++;
        $display("[TB] FAIL mid_wait_press edge %0d: got p=%b, want %b", e, bus.button_pressed, e == 11);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_defaults();
    int shown;
    shown = 0;
    pulse_reset();
    bus2.button = 1'b1;
    for (int e = 0; e <= 40005; e++) begin
      tick();
      checks++;
      if (bus2.button_pressed !== (e == 40002) || bus2.button_level !== (e >= 40002) ||
          dut2.s_Count > 16'd39999) begin
        failures++;
        if (shown < 5)
          $display("[TB] FAIL default_press edge %0d: got p=%b l=%b count=%0d, want p=%b l=%b count<=39999",
                   e, bus2.button_pressed, bus2.button_level, dut2.s_Count, e == 40002, e >= 40002);
        shown++;
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_glitch();
    test_reset_mid_wait();
    test_defaults();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
